// File: rtl/butter_pkg.sv
// Shared constants and types for the Butterworth pole datapath.
// Default sizes, output width helper, FSM encoding, default taps.
package butter_pkg;

   localparam int NTAPS_DEF = 6;
   localparam int DW_DEF    = 16;
   localparam int CW_DEF    = 9;

   // Default Butterworth pole coefficients c1..c6
   localparam int BW_C1 = 178;
   localparam int BW_C2 = 214;
   localparam int BW_C3 = 135;
   localparam int BW_C4 = 65;
   localparam int BW_C5 = 19;
   localparam int BW_C6 = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   // Full-precision width of x + sum of ntaps products
   function automatic int ow_f(
      input int dw,
      input int cw,
      input int ntaps
   );
      return dw + cw + $clog2(ntaps + 1);
   endfunction

endpackage

// File: rtl/butt_tap_line.sv
// NTAPS-deep signed sample history with shift, flush and a k-indexed read.
// Ports: clk_i/nrst_i, flush_i, shift_i, x_i (new sample), k_i, tap_o.
module butt_tap_line #(
   parameter int NTAPS = 6,
   parameter int DW    = 16,
   parameter int AW    = $clog2(NTAPS + 1)
) (
   input  logic                 clk_i,
   input  logic                 nrst_i,
   input  logic                 flush_i,
   input  logic                 shift_i,
   input  logic signed [DW-1:0] x_i,
   input  logic        [AW-1:0] k_i,
   output logic signed [DW-1:0] tap_o
);

   logic signed [DW-1:0] line_q [1:NTAPS];

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         for (int i = 1; i <= NTAPS; i++) begin
            line_q[i] <= '0;
         end
      end else if (flush_i) begin
         for (int i = 1; i <= NTAPS; i++) begin
            line_q[i] <= '0;
         end
      end else if (shift_i) begin
         line_q[1] <= x_i;
         for (int i = 2; i <= NTAPS; i++) begin
            line_q[i] <= line_q[i-1];
         end
      end
   end

   // Index 0 and out-of-range k read as zero
   always_comb begin
      tap_o = '0;
      for (int i = 1; i <= NTAPS; i++) begin
         if (k_i == AW'(i)) begin
            tap_o = line_q[i];
         end
      end
   end

endmodule

// File: rtl/butt_pole_mac_seq.sv
// Time-shared MAC pole section: y[n] = x[n] + sum c_k * x[n-k].
// Ports: clk/nrst, enable, din_* handshake, coef_* write port,
//   coef_err, dout_valid/data_out result, busy.
module butt_pole_mac_seq
   import butter_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEF,
   parameter int DW    = DW_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               enable,
   input  logic                               din_valid,
   output logic                               din_ready,
   input  logic signed [DW-1:0]               din_x,
   input  logic                               coef_wr,
   input  logic [$clog2(NTAPS+1)-1:0]         coef_addr,
   input  logic signed [CW-1:0]               coef_data,
   output logic                               coef_err,
   output logic                               dout_valid,
   output logic signed [ow_f(DW,CW,NTAPS)-1:0] data_out,
   output logic                               busy
);

   localparam int AW = $clog2(NTAPS + 1);
   localparam int OW = ow_f(DW, CW, NTAPS);
   localparam int PW = DW + CW;

   state_e               state_q, state_d;
   logic        [AW-1:0] k_q, k_d;
   logic signed [OW-1:0] acc_q, acc_d;
   logic signed [OW-1:0] dout_q, dout_d;
   logic signed [DW-1:0] xcur_q, xcur_d;
   logic                 dval_q, dval_d;
   logic                 err_q, err_d;
   logic signed [CW-1:0] coef_q [1:NTAPS];

   logic                 coef_we;
   logic                 shift;
   logic                 addr_ok;
   logic signed [DW-1:0] tap;
   logic signed [CW-1:0] coef_sel;
   logic signed [PW-1:0] coef_ext, tap_ext, prod;
   logic signed [OW-1:0] prod_x, din_ext;

   butt_tap_line #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .AW    (AW)
   ) u_line (
      .clk_i   (clk),
      .nrst_i  (nrst),
      .flush_i (~enable),
      .shift_i (shift),
      .x_i     (xcur_q),
      .k_i     (k_q),
      .tap_o   (tap)
   );

   always_comb begin
      coef_sel = '0;
      for (int i = 1; i <= NTAPS; i++) begin
         if (k_q == AW'(i)) begin
            coef_sel = coef_q[i];
         end
      end
   end

   // Signed size casts sign-extend before the full-width product
   assign coef_ext = PW'(coef_sel);
   assign tap_ext  = PW'(tap);
   assign prod     = coef_ext * tap_ext;
   assign prod_x   = OW'(prod);
   assign din_ext  = OW'(din_x);

   assign addr_ok = (coef_addr != '0) &&
                    (coef_addr <= AW'(NTAPS));

   assign din_ready  = enable && (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign data_out   = dout_q;
   assign dout_valid = dval_q;
   assign coef_err   = err_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      xcur_d  = xcur_q;
      dout_d  = dout_q;
      dval_d  = 1'b0;
      err_d   = err_q;
      coef_we = 1'b0;
      shift   = 1'b0;
      if (!enable) begin
         // Flush: drop any in-flight sample, keep data_out
         state_d = ST_IDLE;
         k_d     = '0;
         acc_d   = '0;
         err_d   = 1'b0;
         coef_we = coef_wr && addr_ok &&
                   (state_q == ST_IDLE);
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               coef_we = coef_wr && addr_ok;
               if (din_valid) begin
                  xcur_d  = din_x;
                  acc_d   = din_ext;
                  k_d     = AW'(1);
                  state_d = ST_MAC;
               end
            end
            ST_MAC: begin
               acc_d = acc_q + prod_x;
               k_d   = k_q + AW'(1);
               if (coef_wr) begin
                  err_d = 1'b1;
               end
               if (k_q == AW'(NTAPS)) begin
                  shift   = 1'b1;
                  state_d = ST_OUT;
               end
            end
            ST_OUT: begin
               dout_d  = acc_q;
               dval_d  = 1'b1;
               k_d     = '0;
               state_d = ST_IDLE;
               if (coef_wr) begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         xcur_q  <= '0;
         dout_q  <= '0;
         dval_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         xcur_q  <= xcur_d;
         dout_q  <= dout_d;
         dval_q  <= dval_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 1; i <= NTAPS; i++) begin
            coef_q[i] <= '0;
         end
      end else if (coef_we) begin
         for (int i = 1; i <= NTAPS; i++) begin
            if (coef_addr == AW'(i)) begin
               coef_q[i] <= coef_data;
            end
         end
      end
   end

endmodule
